// File: rtl/demux4_2_buf_if.sv
// Handshake bundle for the 1-to-4 distributor: one select/valid/ready input side,
// four valid/ready output channels with head data and an aggregate busy flag.
interface demux4_2_buf_if #(
  parameter int WIDTH = 16
);
  logic             s1;
  logic             s0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d_in;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] q3;
  logic [WIDTH-1:0] q2;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q0;
  logic             busy;

  modport master (
    output s1, s0, in_valid, d_in, out_ready,
    input  in_ready, out_valid, q3, q2, q1, q0, busy
  );

  modport slave (
    input  s1, s0, in_valid, d_in, out_ready,
    output in_ready, out_valid, q3, q2, q1, q0, busy
  );
endinterface

// File: rtl/demux4_2_buf.sv
// Registered 1-to-4 distributor: word goes to channel {s1,s0}, each channel has its own
// DEPTH-entry FIFO; 1-cycle latency, a stalled consumer only blocks its own channel.
module demux4_2_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  demux4_2_buf_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [1:0]       sel;
  logic [CW-1:0]    cnt    [4];
  logic [PW-1:0]    rd_ptr [4];
  logic [PW-1:0]    wr_ptr [4];
  logic [WIDTH-1:0] mem    [4][DEPTH];
  logic [WIDTH-1:0] head   [4];
  logic [3:0]       full;
  logic [3:0]       vld;
  logic [3:0]       push;
  logic [3:0]       pop;

  assign sel = {bus.s1, bus.s0};

  always_comb begin
    full = '0;
    vld  = '0;
    push = '0;
    pop  = '0;
    for (int i = 0; i < 4; i++) begin
      full[i] = (cnt[i] == CW'(DEPTH));
      vld[i]  = (cnt[i] != '0);
      pop[i]  = vld[i] & bus.out_ready[i];
      push[i] = bus.in_valid & ~full[i] & (sel == 2'(i));
    end
  end

  // Ready looks only at the selected channel's count, never at out_ready.
  assign bus.in_ready  = ~full[sel];
  assign bus.out_valid = vld;
  assign bus.busy      = |vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i]    <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (pop[i] && !push[i]) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.d_in;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head[i] = vld[i] ? mem[i][rd_ptr[i]] : '0;
    end
  end

  assign bus.q0 = head[0];
  assign bus.q1 = head[1];
  assign bus.q2 = head[2];
  assign bus.q3 = head[3];
endmodule

// File: doc/demux4_2_buf.md
Name: demux4_2_buf

Overview:
- Registered 1-to-4 distributor for the 16-bit datapath; the inverse of the 4:1 select mux.
- Routes one input word to one of four output channels, chosen by the two select bits {s1,s0}.
- Each output channel holds a small FIFO with valid/ready handshakes. A downstream stage that stalls blocks only its own channel.
- Sits between the distance-compute datapath and the four result consumers.

Parameters:
- WIDTH, 16, data width of the input and of each output channel.
- DEPTH, 2, entries per channel FIFO. Must be a power of two and >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- s1  input  1  channel select MSB
- s0  input  1  channel select LSB
- in_valid  input  1  input word present
- in_ready  output  1  selected channel can accept
- d_in  input  WIDTH  input data
- out_valid  output  4  bit i: channel i holds data
- out_ready  input  4  bit i: consumer i takes data
- q3  output  WIDTH  channel 3 head data
- q2  output  WIDTH  channel 2 head data
- q1  output  WIDTH  channel 1 head data
- q0  output  WIDTH  channel 0 head data
- busy  output  1  any channel non-empty

Behaviour:
- Clocking and reset: single clock domain, rising edge. rst_n is sampled only on the clk edge (synchronous, active-low).
- Reset values while rst_n=0 at the edge:
  - all channel counts, read pointers and write pointers = 0
  - out_valid = 4'b0000, busy = 0, q0..q3 = 0
  - in_ready is combinational and reflects the empty FIFOs (1) after reset.
- Reset mid-operation discards all buffered words. No partial transfers survive.
- Channel select: sel = {s1,s0}. 11 -> ch3, 10 -> ch2, 01 -> ch1, 00 -> ch0. Same encoding as the 4:1 mux.
- in_ready = NOT full[sel]:
  - combinational from s1, s0 and the channel counts only
  - independent of in_valid and out_ready (no comb path from out_ready to in_ready)
- Push: on an edge where in_valid=1 and in_ready=1, d_in is written to channel sel. Its count increments unless that channel also pops in the same cycle.
- s1, s0 and d_in must be stable while in_valid=1 and in_ready=0. Changing sel while stalled re-targets the request (no error, no latching).
- Pop: channel i pops on an edge where out_valid[i]=1 and out_ready[i]=1.
- out_valid[i] = (count[i] != 0), driven from registers.
- q_i = head entry of channel i when out_valid[i]=1, else 0. Deterministic zero when empty.
- Latency: a word accepted at edge N is visible on q_sel with out_valid[sel]=1 in the cycle after edge N. There is no bypass: minimum 1 cycle, even into an empty channel.
- Ordering: FIFO order is preserved within each channel. No ordering guarantee across channels.
- Full channel: in_ready=0 when sel targets a channel with count==DEPTH, even if that channel pops in the same cycle. The push is retried next cycle.
- Simultaneous push and pop on the same non-full channel: count unchanged, both pointers advance. Empty+push+no pop: count 0->1.
- Pops on different channels and a push on another channel in the same cycle are all independent.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits and saturates by construction; it never exceeds DEPTH.
- busy = OR of out_valid. Registered-derived, no dependency on inputs.
- out_ready[i] while out_valid[i]=0 has no effect.

Test Plan:
1. Reset then idle.
   - Stimulus: rst_n=0 for 2 cycles, then release, in_valid=0.
   - Required: out_valid=0000, busy=0, q0..q3=0000, in_ready=1 for every sel.
2. Route all four channels.
   - Stimulus: out_ready=0000. Push 0x1111 (sel 00), 0x2222 (01), 0x3333 (10), 0x4444 (11) on consecutive cycles.
   - Required: q0=1111, q1=2222, q2=3333, q3=4444; out_valid=1111; each word visible exactly 1 cycle after its accept edge.
3. Fill and backpressure on ch2.
   - Stimulus: sel=10, out_ready[2]=0. Push 0xA001, 0xA002, then offer 0xA003.
   - Required: in_ready=0 on the third offer.
   - Then: raise out_ready[2] for one cycle.
   - Required: q2=A001 pops, then q2=A002. in_ready returns to 1 the cycle after the pop, and 0xA003 is accepted then, behind 0xA002.
4. Concurrent push/pop on ch1.
   - Stimulus: ch1 holds 0x0005; out_ready[1]=1; push 0x0006 to sel 01 in the same cycle.
   - Required: count stays 1; next cycle q1=0006.
5. Sel change while stalled.
   - Stimulus: ch3 full; hold in_valid=1 with sel=11, then switch to sel=00.
   - Required: in_ready goes 0 -> 1 in the same cycle as the sel change; the word lands in ch0 only; ch3 is unchanged.
6. Reset mid-operation.
   - Stimulus: ch0 and ch2 non-empty; assert rst_n=0 for one edge.
   - Required: after that edge out_valid=0000, busy=0, all q=0; subsequent pushes start from empty.
